// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// ----------
// Fetch-stage sequencer for the pipelined RISC-V core. It owns the program
// counter and talks to a single-port, variable-latency instruction memory
// through a req/ack handshake. It also loads the IF/ID pipeline register.
// Execute-stage redirects (PCsrcE/PCtargetE) take priority over everything.
// Decode back-pressure (StallF) freezes IF/ID. A one-entry skid register
// catches the word that arrives while IF/ID is frozen.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   PCsrcE        redirect request from execute
//   PCtargetE     redirect target address
//   StallF        decode cannot accept; IF/ID holds
//   imem_req      instruction memory request
//   imem_addr     request address, stable until acked
//   imem_ack      imem_rdata valid (only looked at while imem_req is high)
//   imem_rdata    instruction word from memory
//   instrD        IF/ID instruction (0 = bubble)
//   PCD           IF/ID PC
//   PCplus4D      IF/ID next-sequential (word) address
//   validD        IF/ID holds a live instruction
//   FlushD        one-cycle pulse after each accepted redirect
//   err_timeout   sticky; a request waited MAX_WAIT cycles without ack
module fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PCsrcE,
    input  logic [ADDR_WIDTH-1:0] PCtargetE,
    input  logic                  StallF,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           instrD,
    output logic [ADDR_WIDTH-1:0] PCD,
    output logic [ADDR_WIDTH-1:0] PCplus4D,
    output logic                  validD,
    output logic                  FlushD,
    output logic                  err_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int                    CW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]         WAIT_MAX = CW'(MAX_WAIT);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE   = ADDR_WIDTH'(1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [ADDR_WIDTH-1:0] drain_addr;
    logic [ADDR_WIDTH-1:0] skid_pc;
    logic [31:0]           skid_instr;
    logic [CW-1:0]         wait_cnt;
    logic                  redirect;
    logic                  load_mem;
    logic                  load_skid;
    logic                  capture_skid;
    logic                  enter_drain;
    logic                  ifid_busy;

    assign ifid_busy = validD && StallF;

    // Next-state and handshake decode. The memory address normally follows
    // the PC. The exception is DRAIN: a redirect arrived while a request was
    // still outstanding, and the memory must keep seeing the old address
    // until it acks. By then the PC already points at the redirect target.
    // The control strobes produced here steer the datapath registers below.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        imem_req     = 1'b0;
        imem_addr    = pc;
        redirect     = 1'b0;
        load_mem     = 1'b0;
        load_skid    = 1'b0;
        capture_skid = 1'b0;
        enter_drain  = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                redirect = PCsrcE;
                if (imem_ack) begin
                    if (PCsrcE) begin
                        pc_nxt = PCtargetE;
                    end else if (!ifid_busy) begin
                        load_mem = 1'b1;
                        pc_nxt   = pc + PC_ONE;
                    end else begin
                        capture_skid = 1'b1;
                        pc_nxt       = pc + PC_ONE;
                        state_nxt    = HOLD;
                    end
                end else if (PCsrcE) begin
                    pc_nxt      = PCtargetE;
                    enter_drain = 1'b1;
                    state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                redirect  = PCsrcE;
                if (PCsrcE) begin
                    pc_nxt = PCtargetE;
                end
                if (imem_ack) begin
                    state_nxt = FETCH;
                end
            end
            HOLD: begin
                redirect = PCsrcE;
                if (PCsrcE) begin
                    pc_nxt    = PCtargetE;
                    state_nxt = FETCH;
                end else if (!StallF) begin
                    load_skid = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register and program counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Side registers. drain_addr remembers the address of the request being
    // drained. The skid entry holds the word that arrived while decode was
    // stalled. FlushD marks the cycle after any accepted redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_addr <= RESET_PC;
            skid_pc    <= '0;
            skid_instr <= '0;
            FlushD     <= 1'b0;
        end else begin
            FlushD <= redirect;
            if (enter_drain) begin
                drain_addr <= pc;
            end
            if (capture_skid) begin
                skid_pc    <= pc;
                skid_instr <= imem_rdata;
            end
        end
    end

    // IF/ID pipeline register. A redirect squashes the entry, even when
    // decode is stalled. Otherwise a stall freezes it. Otherwise it takes
    // a fresh memory word or the skid entry. If there is neither, it turns
    // into a bubble. On a bubble, PCD/PCplus4D keep their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrD   <= '0;
            PCD      <= '0;
            PCplus4D <= '0;
            validD   <= 1'b0;
        end else if (redirect) begin
            instrD   <= '0;
            PCD      <= '0;
            PCplus4D <= '0;
            validD   <= 1'b0;
        end else if (ifid_busy) begin
            validD <= 1'b1;
        end else if (load_mem) begin
            instrD   <= imem_rdata;
            PCD      <= pc;
            PCplus4D <= pc + PC_ONE;
            validD   <= 1'b1;
        end else if (load_skid) begin
            instrD   <= skid_instr;
            PCD      <= skid_pc;
            PCplus4D <= skid_pc + PC_ONE;
            validD   <= 1'b1;
        end else begin
            instrD <= '0;
            validD <= 1'b0;
        end
    end

    // Wait-state watchdog. It counts cycles spent waiting on an
    // unacknowledged request, and saturates at MAX_WAIT. The error flag is
    // set on the step that reaches MAX_WAIT and stays set until reset. The
    // fetch itself keeps waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else if (imem_req) begin
            if (imem_ack) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + CW'(1);
                if (wait_cnt == WAIT_MAX - CW'(1)) begin
                    err_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// -------------
// Directed bench for fetch_ctrl. A behavioural instruction memory returns
// 0x1000 + address after a programmable number of wait states. Each
// scenario pushes the PC sequence that decode should accept onto a
// scoreboard queue. Every cycle in which decode accepts an IF/ID entry pops
// one expected PC and compares PCD, instrD and PCplus4D against it. Cycle-
// exact checks cover reset, redirect, drain, stall/skid, timeout and wrap.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        PCsrcE;
    logic [31:0] PCtargetE;
    logic        StallF;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instrD;
    logic [31:0] PCD;
    logic [31:0] PCplus4D;
    logic        validD;
    logic        FlushD;
    logic        err_timeout;

    int          vectors;
    int          miscompares;
    int          waitStates;
    logic        ackEn;
    int          memWait;
    logic [31:0] sbQueue[$];

    fetch_ctrl #(
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0),
        .MAX_WAIT  (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCsrcE     (PCsrcE),
        .PCtargetE  (PCtargetE),
        .StallF     (StallF),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instrD     (instrD),
        .PCD        (PCD),
        .PCplus4D   (PCplus4D),
        .validD     (validD),
        .FlushD     (FlushD),
        .err_timeout(err_timeout)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory model. The ack rises once a request has waited
    // waitStates cycles. ackEn lets a scenario hold the ack off entirely.
    assign imem_ack   = imem_req && ackEn && (memWait >= waitStates);
    assign imem_rdata = memWord(imem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            memWait <= 0;
        end else if (imem_req && !imem_ack) begin
            memWait <= memWait + 1;
        end else begin
            memWait <= 0;
        end
    end

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h1000 + addr;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic pcsrc, input logic [31:0] target,
                                 input logic stall);
        PCsrcE    = pcsrc;
        PCtargetE = target;
        StallF    = stall;
    endtask

    // One clock cycle, entered and left at 1 unit after a rising edge. If
    // decode accepts the IF/ID entry at the coming edge, the entry is
    // scored against the queue first.
    task automatic stepCycle();
        logic [31:0] ep;
        if (validD && !StallF && !PCsrcE) begin
            checkOutput("delivery expected", 32'(sbQueue.size() != 0), 32'd1);
            if (sbQueue.size() != 0) begin
                ep = sbQueue.pop_front();
                checkOutput("PCD order", PCD, ep);
                checkOutput("instrD", instrD, memWord(ep));
                checkOutput("PCplus4D", PCplus4D, ep + 32'd1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Reset the DUT and check every output while reset is held. Control
    // returns 1 unit after the first edge following reset release, which
    // is the first cycle in FETCH.
    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        sbQueue.delete();
        #1;
        checkOutput("reset imem_req", 32'(imem_req), 32'd0);
        checkOutput("reset imem_addr", imem_addr, 32'h0);
        checkOutput("reset validD", 32'(validD), 32'd0);
        checkOutput("reset instrD", instrD, 32'h0);
        checkOutput("reset FlushD", 32'(FlushD), 32'd0);
        checkOutput("reset err_timeout", 32'(err_timeout), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic checkDrained(input string tag);
        checkOutput(tag, 32'(sbQueue.size()), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        waitStates  = 0;
        ackEn       = 1'b1;

        $display("[TB] zero-wait streaming");
        resetDut();
        checkOutput("first req", 32'(imem_req), 32'd1);
        checkOutput("first addr", imem_addr, 32'h0);
        checkOutput("no instr after 1st edge", 32'(validD), 32'd0);
        sbQueue.push_back(32'h0);
        sbQueue.push_back(32'h1);
        sbQueue.push_back(32'h2);
        sbQueue.push_back(32'h3);
        stepCycle();
        for (int i = 0; i < 4; i++) begin
            checkOutput("validD streaming", 32'(validD), 32'd1);
            stepCycle();
        end
        checkDrained("stream drained");

        $display("[TB] redirect with ack");
        resetDut();
        sbQueue.push_back(32'h0);
        sbQueue.push_back(32'h1);
        sbQueue.push_back(32'h2);
        sbQueue.push_back(32'h3);
        sbQueue.push_back(32'h40);
        sbQueue.push_back(32'h41);
        repeat (5) stepCycle();
        checkOutput("addr before redirect", imem_addr, 32'h5);
        applyStimulus(1'b1, 32'h40, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("FlushD pulse", 32'(FlushD), 32'd1);
        checkOutput("validD flushed", 32'(validD), 32'd0);
        checkOutput("addr at target", imem_addr, 32'h40);
        stepCycle();
        checkOutput("PCD target", PCD, 32'h40);
        checkOutput("instrD target", instrD, 32'h1040);
        checkOutput("FlushD one cycle", 32'(FlushD), 32'd0);
        stepCycle();
        stepCycle();
        checkDrained("redirect drained");

        $display("[TB] redirect while waiting (3 wait states)");
        waitStates = 3;
        resetDut();
        sbQueue.push_back(32'h0);
        sbQueue.push_back(32'h1);
        sbQueue.push_back(32'h80);
        repeat (9) stepCycle();
        checkOutput("req at addr 2", imem_addr, 32'h2);
        applyStimulus(1'b1, 32'h80, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("drain keeps addr", imem_addr, 32'h2);
        checkOutput("drain keeps req", 32'(imem_req), 32'd1);
        checkOutput("drain FlushD", 32'(FlushD), 32'd1);
        stepCycle();
        checkOutput("drain addr until ack", imem_addr, 32'h2);
        stepCycle();
        checkOutput("next req at target", imem_addr, 32'h80);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stale instr absent", 32'(instrD == 32'h1002), 32'd0);
            stepCycle();
        end
        checkOutput("PCD after drain", PCD, 32'h80);
        stepCycle();
        checkDrained("drain drained");
        waitStates = 0;

        $display("[TB] stall with skid");
        resetDut();
        sbQueue.push_back(32'h0);
        sbQueue.push_back(32'h1);
        sbQueue.push_back(32'h2);
        sbQueue.push_back(32'h3);
        sbQueue.push_back(32'h4);
        sbQueue.push_back(32'h5);
        repeat (3) stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("stall req low", 32'(imem_req), 32'd0);
            checkOutput("stall PCD hold", PCD, 32'h2);
            checkOutput("stall validD hold", 32'(validD), 32'd1);
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (4) stepCycle();
        checkDrained("stall drained");

        $display("[TB] wait-state timeout");
        ackEn = 1'b0;
        resetDut();
        repeat (14) stepCycle();
        checkOutput("no timeout at 14", 32'(err_timeout), 32'd0);
        stepCycle();
        checkOutput("timeout at 15", 32'(err_timeout), 32'd1);
        repeat (4) stepCycle();
        ackEn = 1'b1;
        stepCycle();
        checkOutput("timeout sticky", 32'(err_timeout), 32'd1);
        checkOutput("late ack delivered", 32'(validD), 32'd1);
        checkOutput("late ack PCD", PCD, 32'h0);

        $display("[TB] PC wrap");
        resetDut();
        sbQueue.push_back(32'hFFFF_FFFF);
        sbQueue.push_back(32'h0);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("wrap target addr", imem_addr, 32'hFFFF_FFFF);
        stepCycle();
        checkOutput("wrap PCplus4D", PCplus4D, 32'h0);
        stepCycle();
        stepCycle();
        checkDrained("wrap drained");

        rst = 1'b1;
        #1;
        checkOutput("final reset err", 32'(err_timeout), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer for the pipelined RISC-V core. It owns the program counter and drives a single-port, variable-latency instruction memory through a req/ack handshake. It applies execute-stage redirects (PCsrcE/PCtargetE) and decode back-pressure (StallF), and loads the IF/ID pipeline register (instrD, PCD, PCplus4D, validD). It replaces the free-running PC flop, allowing instruction memory with wait states.

## Interface
- ADDR_WIDTH, 32, PC and memory address width (word addressed)
- RESET_PC, 0, first fetch address after reset
- MAX_WAIT, 15, wait cycles without ack before err_timeout sets

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- PCsrcE  in  1  redirect request from execute
- PCtargetE  in  ADDR_WIDTH  redirect target
- StallF  in  1  decode cannot accept; IF/ID holds
- imem_req  out  1  instruction memory request
- imem_addr  out  ADDR_WIDTH  request address; stable while imem_req high and not acked
- imem_ack  in  1  imem_rdata valid; sampled only while imem_req high
- imem_rdata  in  32  instruction word
- instrD  out  32  IF/ID instruction (0 = bubble)
- PCD  out  ADDR_WIDTH  IF/ID PC
- PCplus4D  out  ADDR_WIDTH  IF/ID next-sequential address (PCD+1, word addressed)
- validD  out  1  IF/ID holds a live instruction
- FlushD  out  1  registered one-cycle pulse after each accepted redirect
- err_timeout  out  1  sticky; set when a request waits MAX_WAIT cycles

## Operation
- Reset values:
  - State: IDLE.
  - PC and imem_addr: RESET_PC.
  - All other outputs: 0. Wait counter: 0.
- States:
  - IDLE: imem_req=0. Next edge goes to FETCH.
  - FETCH: imem_req=1, imem_addr=PC. At an edge:
    - ack and PCsrcE: discard rdata; PC<=PCtargetE; stay in FETCH.
    - ack and no PCsrcE, with IF/ID free (validD=0 or StallF=0): load instrD=rdata, PCD=PC, PCplus4D=PC+1, validD=1; PC<=PC+1; stay in FETCH.
    - ack and no PCsrcE, with IF/ID occupied (validD=1 and StallF=1): store rdata/PC in the skid register; PC<=PC+1; go to HOLD.
    - no ack and PCsrcE: PC<=PCtargetE; go to DRAIN. imem_addr keeps the old address.
  - DRAIN: imem_req=1 with the old address. On ack, discard rdata and go to FETCH with imem_addr=PC. A further PCsrcE in DRAIN overwrites PC.
  - HOLD: imem_req=0.
    - When StallF=0: move the skid register into IF/ID; go to FETCH.
    - On PCsrcE: drop the skid entry; PC<=PCtargetE; go to FETCH. PCsrcE has priority over StallF.
- IF/ID rules, in priority order:
  - Accepted redirect: validD<=0, instrD<=0, PCD/PCplus4D<=0.
  - Else StallF=1 and validD=1: hold.
  - Else load new data if available.
  - Else validD<=0, instrD<=0.
- A redirect is accepted on any edge where PCsrcE=1 and the state is not IDLE. FlushD<=1 for the following cycle only.
- PC arithmetic is modulo 2^ADDR_WIDTH; all-ones+1 wraps to 0.
- Wait counter:
  - Increments each cycle imem_req=1 and imem_ack=0; clears on ack.
  - Saturates at MAX_WAIT; reaching MAX_WAIT sets err_timeout.
  - err_timeout clears only on rst. The fetch keeps waiting.
- rst mid-request abandons the outstanding request. The memory must tolerate imem_req dropping.

## Timing
- Reset release: first edge IDLE->FETCH; imem_req rises that cycle. With same-cycle ack, validD=1 with instrD=mem[RESET_PC] after the second edge.
- Zero-wait memory throughput: 1 instruction/cycle. N wait states: 1 per N+1 cycles.
- Redirect in FETCH with ack:
  - Next cycle: imem_addr=PCtargetE, FlushD=1, validD=0.
  - Target instruction reaches IF/ID one edge later if acked immediately.
- Redirect without ack: the target fetch starts the cycle after the old request's ack.
- Simultaneous PCsrcE and StallF: redirect wins, and IF/ID is cleared despite the stall.

## Test plan
- Zero-wait memory with ack tied to req, mem[i]=0x1000+i, after reset: PCD=0,1,2,3 on consecutive cycles; validD stays 1 from the 2nd edge.
- PCsrcE pulse with PCtargetE=0x40 while PC=5, zero-wait memory:
  - Next cycle: FlushD=1, validD=0, imem_addr=0x40.
  - Following cycle: PCD=0x40, instrD=mem[0x40].
- 3-wait-state memory with PCsrcE (target 0x80) one cycle after req at addr 2:
  - imem_addr stays 2 until ack; that instruction never appears in instrD.
  - The next request is at 0x80.
- StallF high for 4 cycles during zero-wait streaming:
  - IF/ID holds, one word sits in the skid register, imem_req=0.
  - After release: PCD is sequential, with no skipped or duplicated address.
- ack held low for 20 cycles, MAX_WAIT=15: err_timeout rises after 15 waiting cycles and stays 1 after a late ack; rst clears it.
- PCtargetE=0xFFFFFFFF, then streaming: PCD=0xFFFFFFFF then 0x0; PCplus4D of the first word = 0.
